f5_bias_add: RTL and testbench
==============================

Name: f5_bias_add

Overview:
- Downstream consumer of the F5 bias stream; sits between the F5 bias buffer and the F5 output stage.
- Captures the NUM per-neuron biases delivered as (enable, 1-based neuron number, bias) into a local register file.
- Adds the matching bias to each F5 accumulator result, saturates the sum to the output width and emits the neuron result with its index through a 2-stage pipeline.

Parameters:
- WD, 8, bias width (signed two's complement)
- NUM, 120, number of F5 neurons / bias entries
- AW, 24, accumulator input width (signed)
- OW, 8, output data width (signed)

Ports:
- i_sclk  input  1  system clock, all logic on rising edge
- i_rst  input  1  reset, asynchronous, active-high
- i_b_en  input  1  bias write strobe, one bias per cycle
- i_b_num  input  8  1-based bias index, valid range 1..NUM
- i_bias  input  WD  signed bias value
- i_acc_en  input  1  accumulator result valid
- i_acc_num  input  8  1-based neuron index of i_acc
- i_acc  input  AW  signed accumulated dot product
- o_ready  output  1  all NUM biases loaded
- o_en  output  1  output valid pulse
- o_num  output  8  1-based neuron index of o_data
- o_data  output  OW  signed saturated result
- o_err  output  1  one-cycle error flag, aligned with o_en

Behaviour:
- Reset (async, i_rst=1):
  - o_ready, o_en and o_err go to 0; o_num and o_data go to 0.
  - The load counter and the pipeline valid bits clear.
  - Bias memory contents are not cleared, but o_ready=0 marks them invalid.
- Bias load:
  - A write occurs when i_b_en=1 and 1 <= i_b_num <= NUM; it stores i_bias in entry i_b_num-1.
  - A write with i_b_num=0 or i_b_num>NUM is ignored and does not count.
  - Load counter load_cnt (8 bit) increments on each valid write.
  - When a valid write with i_b_num=1 occurs: o_ready clears to 0 next cycle and load_cnt restarts at 1, so a reload invalidates the old set.
  - When load_cnt reaches NUM, o_ready=1 next cycle and stays 1 until reset or the next restart.
  - Writes beyond NUM without a restart keep o_ready=1 and update entries in place.
- Accumulator path, 2-cycle latency (input accepted at cycle T, o_en at T+2):
  - Stage 1 registers i_acc, i_acc_num and the bias read from entry i_acc_num-1.
    - It also registers the error condition: o_ready=0, or i_acc_num outside 1..NUM.
  - Stage 2 computes sum = sign-extend(acc) + sign-extend(bias) at AW+1 bits.
    - Saturates to [-2^(OW-1), 2^(OW-1)-1] and registers o_data, o_num and o_en=1.
  - On error: o_en=1, o_err=1, o_data=0 and o_num is the received index; no stall.
- Flow: no backpressure; i_acc_en may be asserted every cycle, giving back-to-back o_en pulses.
- When i_acc_en=0, o_en=0 and o_err=0 next-next cycle; o_data and o_num hold their last values.
- Simultaneous bias write and accumulator read of the same entry: the read returns the value before the write (read-before-write).
- Simultaneous restart (i_b_num=1) and i_acc_en in the same cycle: the accumulator sees the pre-restart o_ready value.
- Reset mid-pipeline discards in-flight results; no o_en pulse is produced for them.

Optional Feature:
- Macro F5_BIAS_RELU_EN.
- When defined: after saturation, negative results are clamped to 0 (ReLU fused into the F5 output); o_data is always >= 0.
- When undefined: the signed saturated sum is output unchanged.
- Error outputs are 0 in both modes.

Test Plan:
- Load biases 1..120 with value (k mod 128) for index k, then check o_ready:
  - o_ready=0 through the 119th write, 1 on the cycle after the 120th.
- With biases loaded, i_acc=100 and i_acc_num=5 (bias 5) at cycle T:
  - o_en=1, o_num=5, o_data=105 at T+2, o_err=0.
- Saturation, with bias 127 at index 127 mod... use index 100 (bias 100):
  - i_acc=1000 -> o_data=127.
  - i_acc=-5000 -> o_data=-128; with F5_BIAS_RELU_EN, o_data=0.
- Error handling:
  - i_acc_en before the load completes, i_acc_num=3 -> o_en=1, o_err=1, o_data=0, o_num=3.
  - After load, i_acc_num=0 or 121 -> o_err=1.
- Reload:
  - After ready, write i_b_num=1 -> o_ready=0 next cycle.
  - Rewrite all 120 -> o_ready=1.
  - Same-cycle write and read of index 7 (old bias 7, new bias -1) with i_acc=10 -> o_data=17.
- Back-to-back and reset:
  - 120 consecutive i_acc_en cycles -> 120 consecutive o_en pulses in order.
  - Assert i_rst mid-stream -> o_en, o_ready and o_err fall immediately (async) and no stale pulses follow reset release.

Source files
------------

// File: rtl/f5_bias_add.sv
// F5 bias stage: captures NUM per-neuron biases, then adds them to accumulator results with saturation.
// Optional macro F5_BIAS_RELU_EN clamps negative saturated results to zero.
module f5_bias_add #(
    parameter int WD  = 8,
    parameter int NUM = 120,
    parameter int AW  = 24,
    parameter int OW  = 8
) (
    input  logic                 i_sclk,
    input  logic                 i_rst,
    input  logic                 i_b_en,
    input  logic [7:0]           i_b_num,
    input  logic signed [WD-1:0] i_bias,
    input  logic                 i_acc_en,
    input  logic [7:0]           i_acc_num,
    input  logic signed [AW-1:0] i_acc,
    output logic                 o_ready,
    output logic                 o_en,
    output logic [7:0]           o_num,
    output logic signed [OW-1:0] o_data,
    output logic                 o_err
);

    localparam logic signed [AW:0] SAT_HI = {{(AW+2-OW){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [AW:0] SAT_LO = {{(AW+2-OW){1'b1}}, {(OW-1){1'b0}}};

    logic signed [WD-1:0] bias_mem [NUM];

    logic                 wr_ok;
    logic                 restart;
    logic [7:0]           load_cnt;
    logic [7:0]           cnt_next;
    logic                 ready_next;

    logic signed [WD-1:0] rd_bias;
    logic                 acc_bad;

    logic                 s1_valid;
    logic                 s1_err;
    logic [7:0]           s1_num;
    logic signed [AW-1:0] s1_acc;
    logic signed [WD-1:0] s1_bias;

    logic signed [AW:0]   sum;
    logic signed [OW-1:0] res;

    assign wr_ok   = i_b_en && (i_b_num != '0) && (i_b_num <= 8'(NUM));
    assign restart = wr_ok && (i_b_num == 8'd1);

    // Index 1 restarts the load sequence so a reload invalidates the previous set.
    always_comb begin
        cnt_next   = load_cnt;
        ready_next = o_ready;
        if (wr_ok) begin
            if (restart) begin
                cnt_next   = 8'd1;
                ready_next = (NUM == 1);
            end else begin
                cnt_next   = (load_cnt == 8'hFF) ? load_cnt : load_cnt + 8'd1;
                ready_next = o_ready || (cnt_next == 8'(NUM));
            end
        end
    end

    always_ff @(posedge i_sclk or posedge i_rst) begin
        if (i_rst) begin
            load_cnt <= '0;
            o_ready  <= 1'b0;
        end else begin
            load_cnt <= cnt_next;
            o_ready  <= ready_next;
        end
    end

    always_ff @(posedge i_sclk) begin
        for (int unsigned i = 0; i < NUM; i++) begin
            if (wr_ok && (i_b_num == 8'(i + 1))) begin
                bias_mem[i] <= i_bias;
            end
        end
    end

    // Read mux sees the pre-edge contents, giving read-before-write on a same-cycle hit.
    always_comb begin
        rd_bias = '0;
        for (int unsigned i = 0; i < NUM; i++) begin
            if (i_acc_num == 8'(i + 1)) begin
                rd_bias = bias_mem[i];
            end
        end
    end

    assign acc_bad = !o_ready || (i_acc_num == '0) || (i_acc_num > 8'(NUM));

    always_ff @(posedge i_sclk or posedge i_rst) begin
        if (i_rst) begin
            s1_valid <= 1'b0;
            s1_err   <= 1'b0;
            s1_num   <= '0;
            s1_acc   <= '0;
            s1_bias  <= '0;
        end else begin
            s1_valid <= i_acc_en;
            if (i_acc_en) begin
                s1_err  <= acc_bad;
                s1_num  <= i_acc_num;
                s1_acc  <= i_acc;
                s1_bias <= rd_bias;
            end
        end
    end

    always_comb begin
        sum = {s1_acc[AW-1], s1_acc} + {{(AW+1-WD){s1_bias[WD-1]}}, s1_bias};
        if (sum > SAT_HI) begin
            res = SAT_HI[OW-1:0];
        end else if (sum < SAT_LO) begin
            res = SAT_LO[OW-1:0];
        end else begin
            res = sum[OW-1:0];
        end
`ifdef F5_BIAS_RELU_EN
        if (res[OW-1]) begin
            res = '0;
        end
`endif
    end

    always_ff @(posedge i_sclk or posedge i_rst) begin
        if (i_rst) begin
            o_en   <= 1'b0;
            o_err  <= 1'b0;
            o_num  <= '0;
            o_data <= '0;
        end else if (s1_valid) begin
            o_en   <= 1'b1;
            o_err  <= s1_err;
            o_num  <= s1_num;
            o_data <= s1_err ? '0 : res;
        end else begin
            o_en   <= 1'b0;
            o_err  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_f5_bias_add.sv
// Self-checking bench for f5_bias_add: directed steps plus random traffic against a behavioural model.
module tb_f5_bias_add;

    logic              i_sclk = 1'b0;
    logic              i_rst;
    logic              i_b_en;
    logic [7:0]        i_b_num;
    logic signed [7:0] i_bias;
    logic              i_acc_en;
    logic [7:0]        i_acc_num;
    logic signed [23:0] i_acc;
    logic              o_ready;
    logic              o_en;
    logic [7:0]        o_num;
    logic signed [7:0] o_data;
    logic              o_err;

    always #5 i_sclk = ~i_sclk;

    f5_bias_add #(.WD(8), .NUM(120), .AW(24), .OW(8)) dut (
        .i_sclk(i_sclk), .i_rst(i_rst),
        .i_b_en(i_b_en), .i_b_num(i_b_num), .i_bias(i_bias),
        .i_acc_en(i_acc_en), .i_acc_num(i_acc_num), .i_acc(i_acc),
        .o_ready(o_ready), .o_en(o_en), .o_num(o_num), .o_data(o_data), .o_err(o_err)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int m_bias [0:255];
    int m_cnt   = 0;
    bit m_ready = 0;
    bit p_en = 0, p_err = 0;
    int p_num = 0, p_data = 0;
    int h_num = 0, h_data = 0;

    function automatic int sat(input int v);
        int r;
        r = (v > 127) ? 127 : (v < -128) ? -128 : v;
`ifdef F5_BIAS_RELU_EN
        if (r < 0) r = 0;
`endif
        return r;
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_ready = 0;
        p_en = 0; p_err = 0; p_num = 0; p_data = 0;
        h_num = 0; h_data = 0;
    endtask

    // One clock: drive inputs, predict, advance, compare outputs.
    task automatic cycle(input bit b_en, input int b_num, input int bias,
                         input bit a_en, input int a_num, input int acc);
        bit n_err;
        int n_data;
        i_b_en = b_en; i_b_num = 8'(b_num); i_bias = 8'(bias);
        i_acc_en = a_en; i_acc_num = 8'(a_num); i_acc = 24'(acc);
        n_err  = !m_ready || a_num < 1 || a_num > 120;
        n_data = n_err ? 0 : sat(acc + m_bias[a_num]);
        if (b_en && b_num >= 1 && b_num <= 120) begin
            m_bias[b_num] = bias;
            if (b_num == 1) begin
                m_cnt = 1; m_ready = 0;
            end else begin
                if (m_cnt < 255) m_cnt++;
                if (m_cnt == 120) m_ready = 1;
            end
        end
        @(posedge i_sclk); #1;
        if (p_en) begin h_num = p_num; h_data = p_data; end
        chk("o_en",    {31'b0, o_en},    {31'b0, p_en});
        chk("o_err",   {31'b0, o_err},   {31'b0, p_en & p_err});
        chk("o_num",   {24'b0, o_num},   h_num);
        chk("o_data",  32'(o_data),      h_data);
        chk("o_ready", {31'b0, o_ready}, {31'b0, m_ready});
        p_en = a_en; p_err = n_err; p_num = a_num; p_data = n_data;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) m_bias[i] = 0;
        i_rst = 1'b1; i_b_en = 0; i_b_num = 0; i_bias = 0;
        i_acc_en = 0; i_acc_num = 0; i_acc = 0;
        #12;
        chk("rst_o_en",    {31'b0, o_en},    0);
        chk("rst_o_ready", {31'b0, o_ready}, 0);
        chk("rst_o_err",   {31'b0, o_err},   0);
        chk("rst_o_num",   {24'b0, o_num},   0);
        chk("rst_o_data",  32'(o_data),      0);
        @(negedge i_sclk);
        i_rst = 1'b0;

        // Access before load completes is an error
        cycle(0, 0, 0, 1, 3, 50);
        idle(2);

        // Load all biases; o_ready rises only after the final write
        for (int k = 1; k <= 120; k++) cycle(1, k, k % 128, 0, 0, 0);
        idle(1);
        chk("ready_after_load", {31'b0, o_ready}, 1);

        // Basic add, saturation both ways
        cycle(0, 0, 0, 1, 5, 100);
        idle(2);
        chk("basic_data", 32'(o_data), 32'(sat(105)));
        cycle(0, 0, 0, 1, 100, 1000);
        cycle(0, 0, 0, 1, 100, -5000);
        idle(2);

        // Out-of-range indices
        cycle(0, 0, 0, 1, 0, 10);
        cycle(0, 0, 0, 1, 121, 10);
        idle(2);

        // Reload: restart drops ready, then full rewrite
        cycle(1, 1, 1, 0, 0, 0);
        chk("ready_drop", {31'b0, o_ready}, 0);
        for (int k = 2; k <= 120; k++) cycle(1, k, k % 128, 0, 0, 0);
        // Same-cycle write/read of entry 7 returns the old bias
        cycle(1, 7, -1, 1, 7, 10);
        cycle(0, 0, 0, 1, 7, 10);
        idle(2);

        // Back-to-back stream over every neuron
        for (int k = 1; k <= 120; k++)
            cycle(0, 0, 0, 1, k, int'($urandom_range(400)) - 200);
        idle(2);

        // Random traffic, including ignored indices and occasional restarts
        for (int n = 0; n < 600; n++) begin
            int bn, an, ac;
            bn = ($urandom % 100 < 2) ? 1 : int'($urandom_range(125));
            an = int'($urandom_range(125));
            ac = ($urandom % 4 == 0) ? int'($urandom_range(20000)) - 10000
                                     : int'($urandom_range(300)) - 150;
            cycle(bit'($urandom % 2), bn, int'($urandom % 256) - 128,
                  bit'($urandom % 4 != 0), an, ac);
        end
        for (int k = 2; k <= 120; k++) cycle(1, k, int'($urandom % 256) - 128, 0, 0, 0);
        for (int k = 1; k <= 120; k++) cycle(1, 200, 0, 0, 0, 0);
        cycle(1, 1, 3, 0, 0, 0);
        for (int k = 2; k <= 120; k++) cycle(1, k, k % 128, 0, 0, 0);

        // Mid-stream asynchronous reset
        for (int k = 1; k <= 6; k++) cycle(0, 0, 0, 1, k, 20);
        #2;
        i_rst = 1'b1;
        #1;
        chk("async_o_en",    {31'b0, o_en},    0);
        chk("async_o_ready", {31'b0, o_ready}, 0);
        chk("async_o_err",   {31'b0, o_err},   0);
        i_acc_en = 0;
        model_reset();
        @(negedge i_sclk);
        @(negedge i_sclk);
        i_rst = 1'b0;
        idle(4);
        cycle(0, 0, 0, 1, 9, 1);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
